// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand width and the divide-by-zero quotient fill.
package seq_divider_pkg;

   localparam int DIV_WIDTH_DEF = 32;

   // Divide-by-zero quotient is all ones at any width; replicate this bit.
   localparam logic DIV_DBZ_FILL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes,
// one quotient bit per clock, then a sign-fix cycle (truncation toward zero).
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena_div,
   input  logic                    rst_div,
   input  logic signed [WIDTH-1:0] alu_1_a,
   input  logic signed [WIDTH-1:0] alu_1_b,
   output logic signed [WIDTH-1:0] alu_1_out,
   output logic signed [WIDTH-1:0] alu_1_rem,
   output logic                    div_busy,
   output logic                    div_done,
   output logic                    div_by_zero,
   output logic                    div_ovf
);

   localparam int               CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] DBZ_QUOT  = {WIDTH{DIV_DBZ_FILL}};

   div_state_t       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo_q;     // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_a, neg_b;

   logic             cap, b_zero, is_ovf;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, rem_try;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign cap    = (state == ST_IDLE) && ena_div && !rst_div;
   assign b_zero = (alu_1_b == '0);
   assign is_ovf = ($unsigned(alu_1_a) == MIN_VAL) && (alu_1_b == '1);
   assign a_mag  = alu_1_a[WIDTH-1] ? $unsigned(-alu_1_a) : $unsigned(alu_1_a);
   assign b_mag  = alu_1_b[WIDTH-1] ? $unsigned(-alu_1_b) : $unsigned(alu_1_b);

   // Partial remainder is carried one bit wider so the trial subtract's
   // borrow lands in bit WIDTH.
   assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
   assign rem_try = rem_sh - {1'b0, dvs_q};

   assign quo_fix = (neg_a ^ neg_b) ? (~quo_q + 1'b1) : quo_q;
   assign rem_fix = neg_a ? (~rem_q + 1'b1) : rem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rst_div) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (ena_div) state_nxt = (b_zero || is_ovf) ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (!ena_div) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      div_busy = (state != ST_IDLE);
      div_done = (state == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         neg_a       <= 1'b0;
         neg_b       <= 1'b0;
         alu_1_out   <= '0;
         alu_1_rem   <= '0;
         div_by_zero <= 1'b0;
         div_ovf     <= 1'b0;
      end else if (rst_div) begin
         cnt         <= '0;
         alu_1_out   <= '0;
         alu_1_rem   <= '0;
         div_by_zero <= 1'b0;
         div_ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (cap) begin
               quo_q       <= a_mag;
               rem_q       <= '0;
               dvs_q       <= b_mag;
               neg_a       <= alu_1_a[WIDTH-1];
               neg_b       <= alu_1_b[WIDTH-1];
               cnt         <= '0;
               div_by_zero <= 1'b0;
               div_ovf     <= 1'b0;
               // Both special cases bypass the iteration and finish here.
               if (b_zero) begin
                  alu_1_out   <= DBZ_QUOT;
                  alu_1_rem   <= alu_1_a;
                  div_by_zero <= 1'b1;
               end else if (is_ovf) begin
                  alu_1_out <= MIN_VAL;
                  alu_1_rem <= '0;
                  div_ovf   <= 1'b1;
               end
            end
            ST_CALC: begin
               cnt <= cnt + CW'(1);
               if (!rem_try[WIDTH]) begin
                  rem_q <= rem_try[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= rem_sh[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
            end
            ST_FIX: begin
               alu_1_out <= quo_fix;
               alu_1_rem <= rem_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor compares each new div_done against the queue head.
module tb_seq_divider;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               ena_div = 1'b0;
   logic               rst_div = 1'b0;
   logic signed [31:0] alu_1_a = '0;
   logic signed [31:0] alu_1_b = '0;
   logic signed [31:0] alu_1_out, alu_1_rem;
   logic               div_busy, div_done, div_by_zero, div_ovf;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          cap;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .ena_div(ena_div), .rst_div(rst_div),
      .alu_1_a(alu_1_a), .alu_1_b(alu_1_b),
      .alu_1_out(alu_1_out), .alu_1_rem(alu_1_rem),
      .div_busy(div_busy), .div_done(div_done),
      .div_by_zero(div_by_zero), .div_ovf(div_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one comparison set per rising edge of div_done.
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (div_done && !prev_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h rem %h expected none", alu_1_out, alu_1_rem);
            end else begin
               e = sb.pop_front();
               chk({e.name, " quot"}, alu_1_out, e.q);
               chk({e.name, " rem"},  alu_1_rem, e.r);
               chk({e.name, " dbz"},  32'(div_by_zero), 32'(e.dbz));
               chk({e.name, " ovf"},  32'(div_ovf), 32'(e.ovf));
               chk({e.name, " latency"}, 32'(cyc - e.cap + 1), 32'(e.lat));
            end
         end
         prev_done = div_done;
      end
   end

   // Called at a negedge; the next posedge is the capture edge.
   task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dbz,
                        input logic ovf, input int lat, input bit push, input bit hold);
      exp_t e;
      alu_1_a = a;
      alu_1_b = b;
      ena_div = 1'b1;
      if (push) begin
         e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
         e.cap = cyc + 1; e.lat = lat; e.name = name;
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) ena_div = 1'b0;
      alu_1_a = $urandom;
      alu_1_b = $urandom;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = div_done;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = div_done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got done=0 expected done=1 within 60 cycles", name);
      end
      @(negedge clk);
   endtask

   task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic dbz,
                     input logic ovf, input int lat);
      issue(name, a, b, q, r, dbz, ovf, lat, 1'b1, 1'b0);
      wait_done(name);
   endtask

   initial begin
      #1;
      chk("reset out",  alu_1_out, 32'h0);
      chk("reset rem",  alu_1_rem, 32'h0);
      chk("reset busy", 32'(div_busy), 32'h0);
      chk("reset done", 32'(div_done), 32'h0);
      chk("reset dbz",  32'(div_by_zero), 32'h0);
      chk("reset ovf",  32'(div_ovf), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      op("100/7",    32'd100,        32'd7,          32'd14,         32'd2,          0, 0, 34);
      op("-100/7",   -32'sd100,      32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   0, 0, 34);
      op("100/-7",   32'd100,        -32'sd7,        32'hFFFFFFF2,   32'd2,          0, 0, 34);
      op("-100/-7",  -32'sd100,      -32'sd7,        32'd14,         32'hFFFFFFFE,   0, 0, 34);
      op("7/100",    32'd7,          32'd100,        32'd0,          32'd7,          0, 0, 34);
      op("MIN/2",    32'h80000000,   32'd2,          32'hC0000000,   32'd0,          0, 0, 34);
      op("MIN/1",    32'h80000000,   32'd1,          32'h80000000,   32'd0,          0, 0, 34);
      op("5/0",      32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1, 0, 1);
      op("-5/0",     -32'sd5,        32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1, 0, 1);
      op("MIN/-1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0, 1, 1);

      // Abort on the 10th CALC edge; previous result (ovf set) must be cleared.
      issue("abort", 32'd1000, 32'd3, '0, '0, 0, 0, 0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst_div = 1'b1;
      @(negedge clk);
      rst_div = 1'b0;
      chk("abort busy", 32'(div_busy), 32'h0);
      chk("abort out",  alu_1_out, 32'h0);
      chk("abort rem",  alu_1_rem, 32'h0);
      chk("abort ovf",  32'(div_ovf), 32'h0);
      op("9/3",      32'd9,          32'd3,          32'd3,          32'd0,          0, 0, 34);

      // ena_div held through DONE: no restart, done stays high.
      issue("20/6 hold", 32'd20, 32'd6, 32'd3, 32'd2, 0, 0, 34, 1'b1, 1'b1);
      for (int i = 0; i < 60 && !div_done; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("hold done", 32'(div_done), 32'h1);
      chk("hold quot", alu_1_out, 32'd3);
      ena_div = 1'b0;
      @(negedge clk);
      chk("hold release done", 32'(div_done), 32'h0);
      chk("hold release busy", 32'(div_busy), 32'h0);

      // Async reset mid-CALC.
      issue("rst mid", 32'd77, 32'd5, '0, '0, 0, 0, 0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async rst busy", 32'(div_busy), 32'h0);
      chk("async rst done", 32'(div_done), 32'h0);
      chk("async rst out",  alu_1_out, 32'h0);
      chk("async rst rem",  alu_1_rem, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      op("-9/2",     -32'sd9,        32'd2,          32'hFFFFFFFC,   32'hFFFFFFFF,   0, 0, 34);

      repeat (3) @(negedge clk);
      chk("scoreboard empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
